// File: rtl/alu_cmd_uart_rx.sv
// alu_cmd_uart_rx: 8N1 UART receiver that pairs bytes into ALU command frames.
// Byte 0 carries operands (A = [3:0], B = [7:4]); byte 1 carries the opcode in
// [3:0] with a zero upper nibble.
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   rx                serial input, idle high, asynchronous to clk
//   cmd_a/b/op        decoded command fields, held while cmd_valid
//   cmd_valid/ready   command handshake towards the ALU
//   frame_err         one-cycle pulse: bad stop bit or nonzero byte-1 nibble
//   overrun           one-cycle pulse: completed command dropped
//   busy              receiver FSM not idle
module alu_cmd_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [3:0] cmd_a,
  output logic [3:0] cmd_b,
  output logic [3:0] cmd_op,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CNT_W      = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned TMO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TMO_W      = $clog2(TMO_CYCLES + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT / 2) - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rxs_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       pend_q, pend_d;
  logic             idx_q, idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [3:0]       cmd_a_q, cmd_a_d;
  logic [3:0]       cmd_b_q, cmd_b_d;
  logic [3:0]       cmd_op_q, cmd_op_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;

  // State and output registers; synchronizer flops reset to the idle level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      pend_q      <= '0;
      idx_q       <= 1'b0;
      tmo_q       <= '0;
      cmd_a_q     <= '0;
      cmd_b_q     <= '0;
      cmd_op_q    <= '0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rxs_q       <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      pend_q      <= pend_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      cmd_a_q     <= cmd_a_d;
      cmd_b_q     <= cmd_b_d;
      cmd_op_q    <= cmd_op_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  // Receiver FSM, frame assembly, timeout and command handshake.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    pend_d      = pend_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    cmd_a_d     = cmd_a_q;
    cmd_b_d     = cmd_b_q;
    cmd_op_d    = cmd_op_q;
    cmd_valid_d = cmd_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (cmd_valid_q && cmd_ready) begin
      cmd_valid_d = 1'b0;
    end

    // Pending byte 0 expires after a long idle gap; a start bit clears the
    // counter below, so this only ever fires while the line stays idle.
    if (idx_q && (state_q == ST_IDLE)) begin
      if (tmo_q == TMO_LAST) begin
        idx_d = 1'b0;
        tmo_d = '0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (!rxs_q) begin
          state_d = ST_START;
          cnt_d   = '0;
          bit_d   = '0;
          tmo_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rxs_q ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (!rxs_q) begin
            frame_err_d = 1'b1;
            idx_d       = 1'b0;
          end else if (!idx_q) begin
            pend_d = shift_q;
            idx_d  = 1'b1;
            tmo_d  = '0;
          end else if (shift_q[7:4] != 4'd0) begin
            frame_err_d = 1'b1;
            idx_d       = 1'b0;
          end else begin
            idx_d = 1'b0;
            // Loading is allowed when the held command leaves this cycle.
            if (!cmd_valid_q || cmd_ready) begin
              cmd_a_d     = pend_q[3:0];
              cmd_b_d     = pend_q[7:4];
              cmd_op_d    = shift_q[3:0];
              cmd_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign cmd_a     = cmd_a_q;
  assign cmd_b     = cmd_b_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_valid = cmd_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_cmd_uart_rx.sv
// tb_alu_cmd_uart_rx: directed bench for alu_cmd_uart_rx with a frame-level
// behavioural model compared against the DUT on every clock.
module tb_alu_cmd_uart_rx;

  localparam int C  = 16;
  localparam int TB = 20;
  localparam int TC = TB * C;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [3:0] cmd_a, cmd_b, cmd_op;
  logic       cmd_valid, cmd_ready, frame_err, overrun, busy;

  alu_cmd_uart_rx #(.CLKS_PER_BIT(C), .TIMEOUT_BITS(TB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  // One entry per byte or glitch put on the line: n = cycle of the falling
  // edge, s = last busy cycle (stop sample for bytes, start check for glitches).
  typedef struct {
    int         n;
    int         s;
    logic [7:0] data;
    logic       stop_ok;
    logic       glitch;
  } ev_t;

  ev_t ev_q[$];
  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  bit  chk_en = 1'b0;

  // Measurements of DUT behaviour, compared against literals by the stimulus.
  int fe_cnt = 0, ov_cnt = 0, valid_cycles = 0, vrise_cyc = -1;
  int busy_run = 0, busy_run_last = 0;

  // Model state.
  logic       m_idx, m_valid, m_fe, m_ov, m_busy;
  logic [7:0] m_pend;
  logic [3:0] m_a, m_b, m_op;
  int         m_s0;
  logic       rdy_last;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    ev_t e;
    e.n = cyc;
    e.s = cyc + 9 * C + C / 2 + 2;
    e.data = b;
    e.stop_ok = stop_ok;
    e.glitch = 1'b0;
    ev_q.push_back(e);
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(C);
    end
    if (stop_ok) begin
      rx = 1'b1;
      tick(C);
    end else begin
      // Low just long enough to cover the stop sample, then idle high so the
      // receiver does not see a fresh start bit on return to idle.
      rx = 1'b0;
      tick(C / 2 + 1);
      rx = 1'b1;
      tick(C - C / 2 - 1);
    end
  endtask

  task automatic send_glitch();
    ev_t e;
    e.n = cyc;
    e.s = cyc + 2 + C / 2;
    e.data = 8'h00;
    e.stop_ok = 1'b1;
    e.glitch = 1'b1;
    ev_q.push_back(e);
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(2 * C);
  endtask

  // Model update and comparison, half a cycle after each rising edge.
  initial begin
    logic v_before;
    m_idx = 0; m_valid = 0; m_fe = 0; m_ov = 0; m_busy = 0;
    m_pend = 0; m_a = 0; m_b = 0; m_op = 0; m_s0 = 0; rdy_last = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_idx = 0; m_valid = 0; m_fe = 0; m_ov = 0; m_busy = 0;
        m_pend = 0; m_a = 0; m_b = 0; m_op = 0;
        ev_q.delete();
      end else begin
        m_fe = 0;
        m_ov = 0;
        m_busy = 0;
        v_before = m_valid;
        if (m_valid && rdy_last) m_valid = 0;
        for (int i = 0; i < ev_q.size(); i++) begin
          if (cyc >= ev_q[i].n + 3 && cyc <= ev_q[i].s) m_busy = 1;
          if (!ev_q[i].glitch && cyc == ev_q[i].s + 1) begin
            if (!ev_q[i].stop_ok) begin
              m_fe = 1;
              m_idx = 0;
            end else begin
              if (m_idx && (ev_q[i].n - m_s0 + 2 >= TC)) m_idx = 0;
              if (!m_idx) begin
                m_pend = ev_q[i].data;
                m_idx = 1;
                m_s0 = ev_q[i].s;
              end else if (ev_q[i].data[7:4] != 4'd0) begin
                m_fe = 1;
                m_idx = 0;
              end else begin
                m_idx = 0;
                if (!v_before || rdy_last) begin
                  m_a = m_pend[3:0];
                  m_b = m_pend[7:4];
                  m_op = ev_q[i].data[3:0];
                  m_valid = 1;
                end else begin
                  m_ov = 1;
                end
              end
            end
          end
        end
        while (ev_q.size() > 0 && cyc > ev_q[0].s) void'(ev_q.pop_front());
        if (chk_en) begin
          chk("cmd_valid", int'(cmd_valid), int'(m_valid));
          chk("cmd_a", int'(cmd_a), int'(m_a));
          chk("cmd_b", int'(cmd_b), int'(m_b));
          chk("cmd_op", int'(cmd_op), int'(m_op));
          chk("frame_err", int'(frame_err), int'(m_fe));
          chk("overrun", int'(overrun), int'(m_ov));
          chk("busy", int'(busy), int'(m_busy));
        end
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (cmd_valid) valid_cycles++;
        if (busy) busy_run++;
        else if (busy_run != 0) begin
          busy_run_last = busy_run;
          busy_run = 0;
        end
      end
      if (cmd_valid && vrise_cyc < 0) vrise_cyc = cyc;
      rdy_last = cmd_ready;
    end
  end

  // Directed stimulus with hand-computed literal expectations.
  initial begin
    int n1, fe0, vc0, ov0;
    rst = 1'b1;
    rx = 1'b1;
    cmd_ready = 1'b0;
    tick(3);
    chk("reset_valid", int'(cmd_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_fields", int'({cmd_a, cmd_b, cmd_op}), 0);
    rst = 1'b0;
    tick(2);
    chk_en = 1'b1;

    // 0x53, 0x00 held, then accepted.
    send_byte(8'h53, 1'b1);
    n1 = cyc;
    send_byte(8'h00, 1'b1);
    chk("t1_latency", vrise_cyc - n1, 155);
    chk("t1_a", int'(cmd_a), 3);
    chk("t1_b", int'(cmd_b), 5);
    chk("t1_op", int'(cmd_op), 0);
    tick(5);
    chk("t1_held", int'(cmd_valid), 1);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    chk("t1_dropped", int'(cmd_valid), 0);
    chk("t1_keep_a", int'(cmd_a), 3);

    // Ready tied high, then back-to-back second command.
    cmd_ready = 1'b1;
    vc0 = valid_cycles;
    send_byte(8'h27, 1'b1);
    send_byte(8'h01, 1'b1);
    chk("t2_one_cycle", valid_cycles - vc0, 1);
    chk("t2_fields", int'({cmd_a, cmd_b, cmd_op}), 12'h721);
    send_byte(8'h08, 1'b1);
    send_byte(8'h03, 1'b1);
    chk("t2_second", valid_cycles - vc0, 2);
    chk("t2_fields2", int'({cmd_a, cmd_b, cmd_op}), 12'h803);

    // Bad stop bit, then a clean frame.
    fe0 = fe_cnt;
    vc0 = valid_cycles;
    send_byte(8'h53, 1'b0);
    tick(C);
    chk("t3_fe_once", fe_cnt - fe0, 1);
    chk("t3_no_valid", valid_cycles - vc0, 0);
    send_byte(8'h77, 1'b1);
    send_byte(8'h0F, 1'b1);
    chk("t3_fields", int'({cmd_a, cmd_b, cmd_op}), 12'h77F);

    // Nonzero opcode upper nibble; then timeout of a pending byte 0.
    fe0 = fe_cnt;
    vc0 = valid_cycles;
    send_byte(8'hC5, 1'b1);
    send_byte(8'h1C, 1'b1);
    chk("t4_fe_once", fe_cnt - fe0, 1);
    chk("t4_no_valid", valid_cycles - vc0, 0);
    send_byte(8'hA5, 1'b1);
    tick(21 * C);
    send_byte(8'h0A, 1'b1);
    chk("t4_timeout_no_valid", valid_cycles - vc0, 0);
    chk("t4_timeout_no_fe", fe_cnt - fe0, 1);
    send_byte(8'h01, 1'b1);
    chk("t4_after_timeout", int'({cmd_a, cmd_b, cmd_op}), 12'hA01);

    // Overrun while a command is held.
    cmd_ready = 1'b0;
    tick(2);
    ov0 = ov_cnt;
    send_byte(8'h11, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h02, 1'b1);
    chk("t5_overrun_once", ov_cnt - ov0, 1);
    chk("t5_held_fields", int'({cmd_a, cmd_b, cmd_op}), 12'h114);
    chk("t5_held_valid", int'(cmd_valid), 1);
    cmd_ready = 1'b1;
    tick(2);
    chk("t5_accepted", int'(cmd_valid), 0);

    // Short glitch: busy only for the half-bit start check.
    fe0 = fe_cnt;
    send_glitch();
    chk("t6_glitch_busy", busy_run_last, C / 2);
    chk("t6_glitch_no_fe", fe_cnt - fe0, 0);

    // Reset in the middle of the data bits.
    chk_en = 1'b0;
    rx = 1'b0;
    tick(C);
    rx = 1'b1;
    tick(C);
    rx = 1'b0;
    tick(C / 2);
    chk("t6_busy_mid_data", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_fields", int'({cmd_a, cmd_b, cmd_op}), 0);
    chk("t6_rst_flags", int'({cmd_valid, frame_err, overrun, busy}), 0);
    rx = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(4);
    chk_en = 1'b1;
    send_byte(8'h53, 1'b1);
    send_byte(8'h00, 1'b1);
    chk("t6_post_reset", int'({cmd_a, cmd_b, cmd_op}), 12'h350);
    tick(2 * C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
